// File: rtl/basic_down_counter.sv
// rtl/basic_down_counter.sv - presettable cascadable modulo-N down counter
// Borrow chain via bo->bi; ONESHOT=1 parks at zero in a DONE state until reloaded.
module basic_down_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter bit ONESHOT = 1'b0
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             en,
  input  logic             bi,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             bo,
  output logic             done
);

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("basic_down_counter: MODULUS out of range for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] q_d;
  logic             run_ok;
  logic             cnt;

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      state_q <= S_IDLE;
      q       <= '0;
    end else begin
      state_q <= state_d;
      q       <= q_d;
    end
  end

  // Auto-reload counters run straight out of reset; one-shot ones wait for a load.
  always_comb begin
    state_d = state_q;
    q_d     = q;
    run_ok  = (state_q == S_RUN) || ((state_q == S_IDLE) && (ONESHOT == 1'b0));
    cnt     = en && bi && run_ok && !ld;
    bo      = cnt && (q == '0);
    if (ld) begin
      q_d     = (d > QMAX) ? QMAX : d;
      state_d = S_RUN;
    end else if (cnt) begin
      if (q != '0) begin
        q_d     = q - WIDTH'(1);
        state_d = S_RUN;
      end else if (ONESHOT == 1'b1) begin
        state_d = S_DONE;
      end else begin
        q_d     = QMAX;
        state_d = S_RUN;
      end
    end
  end

  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_basic_down_counter.sv
// tb/tb_basic_down_counter.sv - directed bench for basic_down_counter
// Covers reset, auto-reload wrap, load clamp, gating, one-shot and a two-stage cascade.
module tb_basic_down_counter;

  logic       clk = 1'b0;
  logic       mr;
  logic       mrc;

  logic       en_a, bi_a, ld_a;
  logic [3:0] d_a, q_a;
  logic       bo_a, done_a;

  logic       en_b, bi_b, ld_b;
  logic [3:0] d_b, q_b;
  logic       bo_b, done_b;

  logic       en_c, ld_c;
  logic [3:0] d_c0, d_c1, q_c0, q_c1;
  logic       bo_c0, bo_c1, done_c0, done_c1;
  logic       bi_c0;

  int checks   = 0;
  int failures = 0;
  int exp_v;

  always #5 clk = ~clk;

  basic_down_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1'b0)) u_a (
    .clk(clk), .mr(mr), .en(en_a), .bi(bi_a), .ld(ld_a), .d(d_a),
    .q(q_a), .bo(bo_a), .done(done_a)
  );

  basic_down_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1'b1)) u_b (
    .clk(clk), .mr(mr), .en(en_b), .bi(bi_b), .ld(ld_b), .d(d_b),
    .q(q_b), .bo(bo_b), .done(done_b)
  );

  basic_down_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1'b0)) u_c0 (
    .clk(clk), .mr(mrc), .en(en_c), .bi(bi_c0), .ld(ld_c), .d(d_c0),
    .q(q_c0), .bo(bo_c0), .done(done_c0)
  );

  basic_down_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1'b0)) u_c1 (
    .clk(clk), .mr(mrc), .en(en_c), .bi(bo_c0), .ld(ld_c), .d(d_c1),
    .q(q_c1), .bo(bo_c1), .done(done_c1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mr = 1'b0; mrc = 1'b0;
    en_a = 1'b1; bi_a = 1'b1; ld_a = 1'b1; d_a = 4'd7;
    en_b = 1'b1; bi_b = 1'b1; ld_b = 1'b1; d_b = 4'd7;
    en_c = 1'b0; ld_c = 1'b0; d_c0 = 4'd0; d_c1 = 4'd0; bi_c0 = 1'b1;

    // T1: reset holds everything at zero regardless of inputs
    repeat (3) tick();
    chk("t1_q_a", int'(q_a), 0);
    chk("t1_bo_a", int'(bo_a), 0);
    chk("t1_done_a", int'(done_a), 0);
    chk("t1_q_b", int'(q_b), 0);
    chk("t1_done_b", int'(done_b), 0);

    // T2: auto-reload wrap straight out of reset; one-shot stays idle
    ld_a = 1'b0; d_a = 4'd0;
    ld_b = 1'b0; d_b = 4'd0;
    mr = 1'b1;
    #1;
    exp_v = 0;
    for (int i = 0; i < 11; i++) begin
      chk("t2_bo", int'(bo_a), (exp_v == 0) ? 1 : 0);
      tick();
      exp_v = (exp_v == 0) ? 9 : exp_v - 1;
      chk("t2_q", int'(q_a), exp_v);
    end
    chk("t2_idle_q_b", int'(q_b), 0);
    chk("t2_idle_bo_b", int'(bo_b), 0);
    chk("t2_idle_done_b", int'(done_b), 0);

    // T3: load overrides enable, clamp above MODULUS-1, no borrow during load
    ld_a = 1'b1; d_a = 4'd5;
    tick();
    chk("t3_ld5", int'(q_a), 5);
    d_a = 4'd12;
    tick();
    chk("t3_clamp", int'(q_a), 9);
    d_a = 4'd0;
    tick();
    chk("t3_ld0", int'(q_a), 0);
    d_a = 4'd3;
    #1;
    chk("t3_bo_ld", int'(bo_a), 0);
    tick();
    chk("t3_ld3", int'(q_a), 3);

    // T4: decrement only when en and bi both high
    ld_a = 1'b0;
    en_a = 1'b0; bi_a = 1'b1; tick(); chk("t4_en0", int'(q_a), 3);
    en_a = 1'b1; bi_a = 1'b0; tick(); chk("t4_bi0", int'(q_a), 3);
    en_a = 1'b1; bi_a = 1'b1; tick(); chk("t4_both", int'(q_a), 2);
    en_a = 1'b0; bi_a = 1'b0; tick(); chk("t4_none", int'(q_a), 2);
    en_a = 1'b1; bi_a = 1'b1; tick(); chk("t4_both2", int'(q_a), 1);
    en_a = 1'b0;

    // T5: one-shot countdown, parks in DONE, reload exits
    ld_b = 1'b1; d_b = 4'd2; en_b = 1'b1; bi_b = 1'b1;
    tick();
    chk("t5_ld_q", int'(q_b), 2);
    chk("t5_ld_done", int'(done_b), 0);
    ld_b = 1'b0;
    tick();
    chk("t5_q1", int'(q_b), 1);
    chk("t5_bo_q1", int'(bo_b), 0);
    tick();
    chk("t5_q0", int'(q_b), 0);
    chk("t5_bo_q0", int'(bo_b), 1);
    chk("t5_done_pre", int'(done_b), 0);
    tick();
    chk("t5_done_q", int'(q_b), 0);
    chk("t5_done", int'(done_b), 1);
    chk("t5_done_bo", int'(bo_b), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_q", int'(q_b), 0);
      chk("t5_hold_done", int'(done_b), 1);
    end
    ld_b = 1'b1; d_b = 4'd3;
    tick();
    chk("t5_reld_q", int'(q_b), 3);
    chk("t5_reld_done", int'(done_b), 0);
    ld_b = 1'b0; en_b = 1'b0;

    // T6: two-stage decade cascade and asynchronous reset mid-count
    mrc = 1'b1; en_c = 1'b1; ld_c = 1'b1;
    #1;
    chk("t6_bo1_ld", int'(bo_c1), 0);
    tick();
    chk("t6_load00", int'(q_c1) * 10 + int'(q_c0), 0);
    ld_c = 1'b0;
    #1;
    exp_v = 0;
    for (int i = 0; i < 11; i++) begin
      chk("t6_bo1", int'(bo_c1), (exp_v == 0) ? 1 : 0);
      tick();
      exp_v = (exp_v == 0) ? 99 : exp_v - 1;
      chk("t6_val", int'(q_c1) * 10 + int'(q_c0), exp_v);
    end
    repeat (3) tick();
    chk("t6_val86", int'(q_c1) * 10 + int'(q_c0), 86);
    #2 mrc = 1'b0;
    #1;
    chk("t6_async_rst", int'(q_c1) * 10 + int'(q_c0), 0);
    tick();
    chk("t6_rst_hold", int'(q_c1) * 10 + int'(q_c0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
